// File: rtl/xbar_sched_pkg.sv
// Shared types and constants for the per-slave crossbar transaction scheduler.
package xbar_sched_pkg;

    localparam int N_MASTERS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_RESP = 2'd2
    } sched_state_t;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/rr_next_grant.sv
// Rotating priority encoder: first asserted request scanning from ptr upward, wrapping.
module rr_next_grant
    import xbar_sched_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEFAULT,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid,
    output logic [N_MASTERS-1:0] onehot,
    output logic [IDX_W-1:0]     index
);

    logic [IDX_W:0] cand_s;

    // scan candidates in priority order; the first hit wins
    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        index  = '0;
        cand_s = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand_s = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(N_MASTERS)) begin
                cand_s = cand_s - (IDX_W+1)'(N_MASTERS);
            end else begin
                cand_s = cand_s;
            end
            if (!valid && req[cand_s[IDX_W-1:0]]) begin
                valid                     = 1'b1;
                onehot                    = '0;
                onehot[cand_s[IDX_W-1:0]] = 1'b1;
                index                     = cand_s[IDX_W-1:0];
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/xbar_slave_scheduler.sv
// Per-slave scheduler: round-robin arbitration holding the grant for a full
// request/ack (plus read-response) transaction.
module xbar_slave_scheduler
    import xbar_sched_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEFAULT,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] m_req,
    input  logic [N_MASTERS-1:0] m_cmd,
    output logic [N_MASTERS-1:0] m_ack,
    output logic [N_MASTERS-1:0] m_resp,
    output logic                 s_req,
    output logic                 s_cmd,
    input  logic                 s_ack,
    input  logic                 s_resp,
    output logic [N_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy
);

    sched_state_t         state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;

    logic                 sel_valid_s;
    logic [N_MASTERS-1:0] sel_onehot_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic [IDX_W-1:0]     next_ptr_s;

    rr_next_grant #(
        .N_MASTERS(N_MASTERS),
        .IDX_W    (IDX_W)
    ) u_rr (
        .req   (m_req),
        .ptr   (ptr_q),
        .valid (sel_valid_s),
        .onehot(sel_onehot_s),
        .index (sel_idx_s)
    );

    // priority moves just past the master that was served
    always_comb begin
        if (grant_idx_q == IDX_W'(N_MASTERS-1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_q + IDX_W'(1);
        end
    end

    // next-state and slave/master-side outputs
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        s_req       = 1'b0;
        s_cmd       = 1'b0;
        m_ack       = '0;
        m_resp      = '0;
        case (state_q)
            IDLE: begin
                if (sel_valid_s) begin
                    grant_d     = sel_onehot_s;
                    grant_idx_d = sel_idx_s;
                    state_d     = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                s_req = 1'b1;
                s_cmd = m_cmd[grant_idx_q];
                m_ack = grant_q & {N_MASTERS{s_ack}};
                // an ack in the same cycle as a dropped request still completes normally
                if (s_ack) begin
                    if (s_cmd == CMD_WRITE) begin
                        state_d     = IDLE;
                        ptr_d       = next_ptr_s;
                        grant_d     = '0;
                        grant_idx_d = '0;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end else if (!m_req[grant_idx_q]) begin
                    state_d     = IDLE;
                    ptr_d       = next_ptr_s;
                    grant_d     = '0;
                    grant_idx_d = '0;
                end else begin
                    state_d = GRANT;
                end
            end
            WAIT_RESP: begin
                m_resp = grant_q & {N_MASTERS{s_resp}};
                if (s_resp) begin
                    state_d     = IDLE;
                    ptr_d       = next_ptr_s;
                    grant_d     = '0;
                    grant_idx_d = '0;
                end else begin
                    state_d = WAIT_RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        endcase
    end

    // state, priority pointer and grant registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_xbar_slave_scheduler.sv
// Directed scoreboard bench for xbar_slave_scheduler.
module tb_xbar_slave_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] m_req;
    logic [3:0] m_cmd;
    logic [3:0] m_ack;
    logic [3:0] m_resp;
    logic       s_req;
    logic       s_cmd;
    logic       s_ack;
    logic       s_resp;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;

    int total;
    int bad;
    int exp_q[$];

    xbar_slave_scheduler #(.N_MASTERS(4), .IDX_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_cmd    (m_cmd),
        .m_ack    (m_ack),
        .m_resp   (m_resp),
        .s_req    (s_req),
        .s_cmd    (s_cmd),
        .s_ack    (s_ack),
        .s_resp   (s_resp),
        .grant    (grant),
        .grant_idx(grant_idx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_gidx"},  32'(grant_idx), 32'd0);
        chk({tag, "_sreq"},  32'(s_req), 32'd0);
    endtask

    // One transaction from an IDLE cycle; expected winner pushed at drive, popped on completion.
    task automatic run_txn(input logic [3:0] req, input logic [3:0] cmd, input int idx,
                           input int ack_wait, input int resp_wait, input bit hold);
        logic [3:0] oh;
        int         e;
        oh = 4'b0001 << idx;
        m_req = req;
        m_cmd = cmd;
        exp_q.push_back(idx);
        step();
        settle();
        chk("grant",     32'(grant),     32'(oh));
        chk("grant_idx", 32'(grant_idx), 32'(idx));
        chk("s_req",     32'(s_req),     32'd1);
        chk("s_cmd",     32'(s_cmd),     32'(cmd[idx]));
        for (int i = 0; i < ack_wait; i++) begin
            s_resp = 1'b1;
            settle();
            chk("ack_early",     32'(m_ack),  32'd0);
            chk("resp_in_grant", 32'(m_resp), 32'd0);
            step();
            s_resp = 1'b0;
        end
        s_ack = 1'b1;
        settle();
        e = exp_q[0];
        chk("ack", 32'(m_ack), 32'(4'b0001 << e));
        step();
        s_ack = 1'b0;
        if (cmd[idx] == 1'b0) begin
            for (int i = 0; i < resp_wait; i++) begin
                settle();
                chk("rd_sreq",  32'(s_req),  32'd0);
                chk("rd_resp0", 32'(m_resp), 32'd0);
                chk("rd_grant", 32'(grant),  32'(oh));
                step();
            end
            s_resp = 1'b1;
            settle();
            chk("resp",      32'(m_resp), 32'(4'b0001 << e));
            chk("resp_sreq", 32'(s_req),  32'd0);
            step();
            s_resp = 1'b0;
        end
        e = exp_q.pop_front();
        if (!hold) m_req = 4'b0000;
        settle();
        chk_idle("done");
        chk("done_ack", 32'(m_ack), 32'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        m_req  = 4'b0000;
        m_cmd  = 4'b0000;
        s_ack  = 1'b0;
        s_resp = 1'b0;
        #2;
        chk_idle("reset");
        chk("reset_ack",  32'(m_ack),  32'd0);
        chk("reset_resp", 32'(m_resp), 32'd0);
        step();
        rst = 1'b0;

        // single write, ack one cycle late; then ptr=1 makes 1001 pick master 3
        run_txn(4'b0001, 4'b0001, 0, 1, 0, 1'b0);
        run_txn(4'b1001, 4'b1111, 3, 0, 0, 1'b0);
        // read: immediate ack, response three cycles later
        run_txn(4'b0100, 4'b0000, 2, 0, 2, 1'b0);
        // ptr=3 with 0110 wraps to master 1, then master 2
        run_txn(4'b0110, 4'b1111, 1, 0, 0, 1'b0);
        run_txn(4'b0110, 4'b1111, 2, 0, 0, 1'b0);

        // protocol abort: master 2 drops its request before ack
        m_req = 4'b0100;
        m_cmd = 4'b0000;
        step();
        settle();
        chk("abort_grant", 32'(grant), 32'h4);
        m_req = 4'b0000;
        settle();
        chk("abort_ack", 32'(m_ack), 32'd0);
        step();
        settle();
        chk_idle("abort");
        // spurious slave strobes while idle
        s_resp = 1'b1;
        s_ack  = 1'b1;
        settle();
        chk("spur_resp", 32'(m_resp), 32'd0);
        chk("spur_ack",  32'(m_ack),  32'd0);
        step();
        s_resp = 1'b0;
        s_ack  = 1'b0;
        settle();
        chk_idle("spur");

        // ptr=3: read from master 3 with drop and ack in the same cycle; ack wins
        m_req = 4'b1000;
        m_cmd = 4'b0000;
        step();
        m_req = 4'b0000;
        s_ack = 1'b1;
        settle();
        chk("drop_ack", 32'(m_ack), 32'h8);
        step();
        s_ack = 1'b0;
        settle();
        chk("drop_busy", 32'(busy), 32'd1);
        s_resp = 1'b1;
        settle();
        chk("drop_resp", 32'(m_resp), 32'h8);
        step();
        s_resp = 1'b0;
        settle();
        chk_idle("drop");

        // fairness: all four requesting, ptr=0
        for (int k = 0; k < 5; k++) begin
            run_txn(4'b1111, 4'b1111, k % 4, 0, 0, (k < 4));
        end

        // async reset during WAIT_RESP (ptr=1 so master 1 wins)
        m_req = 4'b0010;
        m_cmd = 4'b0000;
        step();
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        settle();
        chk("ar_busy", 32'(busy),  32'd1);
        chk("ar_grant", 32'(grant), 32'h2);
        #1;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        step();
        rst   = 1'b0;
        m_req = 4'b0000;
        s_resp = 1'b1;
        settle();
        chk("ar_resp", 32'(m_resp), 32'd0);
        step();
        s_resp = 1'b0;
        run_txn(4'b1111, 4'b1111, 0, 0, 0, 1'b0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbar_slave_scheduler.md
Name: xbar_slave_scheduler

Overview:
- Per-slave transaction scheduler for the 4x4 cross bar, one instance per slave port.
- Shares a single slave between masters whose decoded address selects that slave, using round-robin priority.
- Holds the grant for one complete transaction: request/ack, plus the read-response phase for reads.
- Drives the slave-side req/cmd, routes ack/resp back to the winning master, and supplies the grant used by the addr/wdata/rdata muxes.

Parameters:
- N_MASTERS, 4, number of requesting masters.
- IDX_W, $clog2(N_MASTERS), width of the master index.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_req  input  N_MASTERS  per-master request, already address-decoded for this slave.
- m_cmd  input  N_MASTERS  per-master command: 1 = write, 0 = read.
- m_ack  output  N_MASTERS  per-master ack, one-hot or zero.
- m_resp  output  N_MASTERS  per-master read-response strobe, one-hot or zero.
- s_req  output  1  request to slave.
- s_cmd  output  1  command to slave (cmd of the granted master).
- s_ack  input  1  slave accepts the current request.
- s_resp  input  1  slave read-data-valid strobe.
- grant  output  N_MASTERS  one-hot granted master; all-zero when idle.
- grant_idx  output  IDX_W  binary index of the granted master; 0 when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0. All outputs 0 immediately, no clock needed. Reset mid-transaction abandons it; no ack or resp is produced afterwards.
- ptr is the highest-priority master index.
- Selection: the first asserted m_req bit scanning ptr, ptr+1, … wrapping modulo N_MASTERS.
- FSM states: IDLE, GRANT, WAIT_RESP.
- IDLE:
  - If m_req != 0: register the selected master into grant/grant_idx and go to GRANT.
  - Otherwise stay. s_req=0.
- GRANT:
  - s_req=1; s_cmd=m_cmd[grant_idx].
  - m_ack[grant_idx]=s_ack, combinational.
  - s_ack=1 and write: go to IDLE; ptr <= grant_idx+1 (wraps N_MASTERS-1 -> 0).
  - s_ack=1 and read: go to WAIT_RESP. ptr is unchanged.
  - m_req[grant_idx]=0 before ack (protocol violation): go to IDLE; ptr <= grant_idx+1; no ack is issued. A same-cycle s_ack takes precedence over the drop.
- WAIT_RESP:
  - s_req=0. grant is held so the rdata mux stays selected.
  - m_resp[grant_idx]=s_resp, combinational.
  - On s_resp=1: go to IDLE; ptr <= grant_idx+1.
  - New requests are ignored until completion.
- Latency:
  - m_req rising in IDLE at cycle 0 gives s_req=1 at cycle 1.
  - The earliest ack is in cycle 1, if the slave acks immediately.
  - The minimum gap between consecutive transactions is one IDLE cycle.
- s_ack or s_resp outside its own phase (IDLE, or s_resp in GRANT) is ignored; no m_ack/m_resp is produced.
- Only the granted master ever sees ack or resp. Other m_req bits have no effect while busy.
- Fairness: with all N_MASTERS requesting continuously, each is served exactly once per N_MASTERS transactions.
- grant/grant_idx change only on the IDLE->GRANT and ->IDLE transitions, and are stable through GRANT and WAIT_RESP.

Decomposition:
- Package xbar_sched_pkg holds:
  - N_MASTERS_DEFAULT constant.
  - sched_state_t enum {IDLE, GRANT, WAIT_RESP}.
  - CMD_WRITE/CMD_READ constants.
- Sub-module rr_next_grant: purely combinational rotating priority encoder (req vector, ptr) -> (valid, one-hot, index). The FSM, ptr and output registers stay in xbar_slave_scheduler.

Test Plan:
- Single write: m_req=0001, m_cmd=0001, s_ack in cycle 2 -> s_req high in cycles 1-2, m_ack=0001 in cycle 2, IDLE in cycle 3, ptr=1.
- Read with latency: m_req=0100, read, s_ack in cycle 1, s_resp in cycle 4 -> grant=0100 through cycle 4, m_resp=0100 only in cycle 4, s_req low in cycles 2-4, ptr=3.
- Round-robin fairness: m_req=1111 held, all writes, slave acks immediately -> grant order 0,1,2,3,0; ptr wraps 3->0.
- Priority skip/wrap: ptr=3, m_req=0110 -> grant_idx=1 (not 2); after completion ptr=2, and the next grant from 0110 is master 2.
- Protocol abort: granted master 2 drops m_req in GRANT with s_ack=0 -> no m_ack, IDLE next cycle, ptr=3. Spurious s_resp in IDLE -> m_resp stays 0000.
- Async reset in WAIT_RESP: rst asserted mid-cycle -> grant, busy, s_req drop to 0 without a clock edge. After release, s_resp=1 -> m_resp=0000 and ptr=0.
